pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Sequences the on-chip PLL (SB_PLL40 family) from power-up to usable clock. It drives the PLL RESETB and BYPASS pins, monitors the asynchronous LOCK output, and qualifies lock over a stability window. It releases a system reset only when lock is stable, retries on timeout, and falls back to bypass after repeated failures. It runs on the PLL reference clock, which is never gated by the PLL.

Parameters:
RESET_CYCLES, 16, cycles PLL RESETB held low per attempt (>=1)
LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before an attempt fails (>=1)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before RUN (>=1)
MAX_RETRIES, 3, failed attempts before entering BYPASS (>=1)
CNT_W, 17, shared cycle counter width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
clock_in  input  1  reference clock, same net as PLL REFERENCECLK
resetn  input  1  asynchronous active-low reset
pll_lock_raw  input  1  PLL LOCK, asynchronous to clock_in
relock_req  input  1  level; forces a fresh attempt
pll_resetb  output  1  to PLL RESETB
pll_bypass  output  1  to PLL BYPASS
sys_rstn  output  1  active-low reset for logic on PLL output clocks
pll_ok  output  1  high only in RUN
bypass_active  output  1  high only in BYPASS
state  output  3  0=RST 1=WAIT_LOCK 2=STABLE 3=RUN 4=BYPASS
loss_count  output  8  saturating count of lock losses from RUN

Behaviour:
- Reset (resetn=0, async): state=RST, cycle counter=0, retry counter=0, loss_count=0, sync flops=0. Outputs: pll_resetb=0, pll_bypass=0, sys_rstn=0, pll_ok=0, bypass_active=0.
- Lock synchronizer: 2-flop chain on pll_lock_raw produces lock_s. Latency is 2 edges.
- All outputs are registered Moore decodes of the next state. They change on the same edge that state changes.
- Output values by state:
  - RST: pll_resetb=0, bypass=0, sys_rstn=0, pll_ok=0, bypass_active=0.
  - WAIT_LOCK and STABLE: pll_resetb=1; all other outputs 0.
  - RUN: pll_resetb=1, sys_rstn=1, pll_ok=1.
  - BYPASS: pll_resetb=0, pll_bypass=1, sys_rstn=1, bypass_active=1, pll_ok=0.
- RST: occupies exactly RESET_CYCLES cycles, then goes to WAIT_LOCK with counter=0.
- WAIT_LOCK:
  - lock_s=1: go to STABLE, counter=0.
  - Otherwise, when counter==LOCK_TIMEOUT-1: retries+1. If the new retry count equals MAX_RETRIES, go to BYPASS; else go to RST.
- STABLE:
  - lock_s=0: attempt fails, handled exactly as a timeout (retries+1, then RST or BYPASS).
  - counter==STABLE_CYCLES-1 with lock_s=1: go to RUN and clear retries.
- RUN: lock_s=0 sends state to RST on the next edge. On that edge sys_rstn and pll_ok fall, loss_count increments (saturates at 255), and retries=0.
- BYPASS: terminal. Exit only via relock_req or resetn.
- relock_req=1 in any state except RST: go to RST, retries=0, counter=0. This has priority over every other same-cycle transition, including timeout and RUN loss; a RUN loss coinciding with relock_req still increments loss_count. In RST, relock_req is ignored and does not restart the count.
- The counter clears on every state change and never wraps; transitions occur exactly at terminal count.
- loss_count is cleared only by resetn.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal lock: release resetn, raise pll_lock_raw 5 cycles into WAIT_LOCK. Required: pll_resetb rises 4 edges after reset release; state=3 and sys_rstn=1 on the 10th edge after pll_lock_raw is first sampled high; pll_ok=1.
2. No lock ever (pll_lock_raw=0): state cycles RST to WAIT_LOCK twice. At edge 48 after reset release, state=4, pll_bypass=1, pll_resetb=0, sys_rstn=1, bypass_active=1.
3. 1-cycle low glitch in STABLE: state returns to RST, pll_ok stays 0. Keep lock high afterwards: RUN is reached and retries clear (a later never-lock run then needs 2 full failures to reach BYPASS).
4. Lock loss in RUN: drop pll_lock_raw. sys_rstn=0 three edges later, loss_count=1, then relock. Repeat 300 times: loss_count saturates at 255.
5. relock_req asserted in BYPASS: next edge state=0, pll_bypass=0. relock_req on the timeout edge: state=RST with retries=0, not BYPASS.
6. Assert resetn mid-RUN, off clock edge: all outputs take reset values immediately without a clock edge; loss_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL power-up sequencer: holds the PLL in reset, qualifies the asynchronous
// LOCK output over a stability window, releases the downstream system reset,
// retries failed attempts and falls back to bypass after repeated failures.
// Runs on the PLL reference clock so it keeps running when the PLL misbehaves.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RST        | PLL RESETB held low for RESET_CYCLES
// WAIT_LOCK  | PLL running, waiting for synchronized lock (bounded by timeout)
// STABLE     | lock seen, must stay high for STABLE_CYCLES consecutive cycles
// RUN        | lock qualified, system reset released
// BYPASS     | retries exhausted, reference clock passed through (terminal)
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       pll_lock_raw,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_rstn,
  output logic       pll_ok,
  output logic       bypass_active,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_BYPASS    = 3'd4
  } state_t;

  localparam int RET_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [RET_W-1:0] MAX_RET   = RET_W'(MAX_RETRIES);
  localparam logic [RET_W-1:0] RET_ONE   = RET_W'(1);

  logic             lock_meta;
  logic             lock_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RET_W-1:0] retry_q;
  logic [RET_W-1:0] retry_d;
  logic [RET_W-1:0] retry_inc;
  logic [7:0]       loss_d;
  logic             attempt_fail;

  assign retry_inc = retry_q + RET_ONE;
  assign state     = state_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_raw;
      lock_s    <= lock_meta;
    end
  end

  // Next-state, counter, retry and loss-count decisions
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    loss_d       = loss_count;
    attempt_fail = 1'b0;

    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_TC) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_TC) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == STABLE_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        // Counter stays at zero here so it can never wrap
        if (!lock_s) begin
          state_d = ST_RST;
          cnt_d   = '0;
          retry_d = '0;
          if (loss_count != 8'hFF) begin
            loss_d = loss_count + 8'd1;
          end
        end
      end
      ST_BYPASS: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase

    // Timeout and lost-while-qualifying are the same failed attempt
    if (attempt_fail) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      state_d = (retry_inc == MAX_RET) ? ST_BYPASS : ST_RST;
    end

    // Relock overrides everything except an RST already in progress;
    // a coinciding RUN loss keeps its loss_count increment above
    if (relock_req && (state_q != ST_RST)) begin
      state_d = ST_RST;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      loss_count    <= 8'd0;
      pll_resetb    <= 1'b0;
      pll_bypass    <= 1'b0;
      sys_rstn      <= 1'b0;
      pll_ok        <= 1'b0;
      bypass_active <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_count    <= loss_d;
      pll_resetb    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_RUN);
      pll_bypass    <= (state_d == ST_BYPASS);
      sys_rstn      <= (state_d == ST_RUN) || (state_d == ST_BYPASS);
      pll_ok        <= (state_d == ST_RUN);
      bypass_active <= (state_d == ST_BYPASS);
    end
  end

endmodule
